// File: rtl/mem_access_unit.sv
// MEM-stage access sequencer in front of data_mem.
// Splits misaligned accesses and aligns and extends load data.

`ifndef MEM_NONE
`define MEM_NONE 4'h0
`endif
`ifndef MEM_SB
`define MEM_SB 4'h1
`endif
`ifndef MEM_SH
`define MEM_SH 4'h2
`endif
`ifndef MEM_SW
`define MEM_SW 4'h3
`endif

module mem_access_unit #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  EX_mem_op,
    input  logic [1:0]  EX_mem_size,
    input  logic        EX_mem_unsigned,
    input  logic [31:0] EX_mem_addr,
    input  logic [31:0] EX_mem_wdata,
    output logic [3:0]  MEM_mem_cmd,
    output logic [31:0] MEM_mem_addr,
    output logic [31:0] MEM_mem_din,
    input  logic [31:0] DM_mem_dout,
    output logic [31:0] MEM_load_data,
    output logic        MEM_load_valid,
    output logic        MEM_stall,
    output logic        MEM_misaligned
);

    typedef enum logic [1:0] {
        IDLE,
        LD2,
        ST_SEQ
    } state_t;

    state_t      state;
    logic [31:0] base_addr;
    logic [31:0] lo_word;
    logic [31:0] wdata_q;
    logic [1:0]  byte_idx;
    logic [1:0]  size_q;
    logic        unsigned_q;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            2'b10:   size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] extend(
        input logic [31:0] v,
        input logic [1:0]  s,
        input logic        u
    );
        case (s)
            2'b00:   extend = u ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            2'b01:   extend = u ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    function automatic logic [3:0] store_cmd(input logic [1:0] s);
        case (s)
            2'b00:   store_cmd = `MEM_SB;
            2'b01:   store_cmd = `MEM_SH;
            2'b10:   store_cmd = `MEM_SW;
            default: store_cmd = `MEM_NONE;
        endcase
    endfunction

    function automatic logic [7:0] pick_byte(
        input logic [31:0] w,
        input logic [1:0]  i
    );
        case (i)
            2'b00:   pick_byte = w[7:0];
            2'b01:   pick_byte = w[15:8];
            2'b10:   pick_byte = w[23:16];
            default: pick_byte = w[31:24];
        endcase
    endfunction

    // Request decode for the access presented in IDLE
    logic       size_ok;
    logic       is_load;
    logic       is_store;
    logic [1:0] off;
    logic [2:0] nbytes;
    logic       aligned;
    logic       crosses;
    logic       reject;

    assign size_ok  = (EX_mem_size != 2'b11);
    assign is_load  = (EX_mem_op == 2'b01) && size_ok;
    assign is_store = (EX_mem_op == 2'b10) && size_ok;
    assign off      = EX_mem_addr[1:0];
    assign nbytes   = size_bytes(EX_mem_size);
    assign crosses  = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
    assign reject   = (is_load || is_store) && !aligned && !SPLIT_MISALIGNED;

    // Alignment test: offset must be a multiple of the access size
    always_comb begin
        aligned = 1'b1;
        case (EX_mem_size)
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // Sequence-side decode from latched request
    logic [2:0]  seq_nbytes;
    logic        seq_last;
    logic [31:0] idle_word;
    logic [31:0] ld2_word;

    assign seq_nbytes = size_bytes(size_q);
    assign seq_last   = ({1'b0, byte_idx} == (seq_nbytes - 3'd1));
    assign idle_word  = DM_mem_dout >> {off, 3'b000};

    // Join the two halves of a word-crossing load at the original offset
    always_comb begin
        ld2_word = lo_word;
        case (base_addr[1:0])
            2'b01:   ld2_word = {DM_mem_dout[7:0], lo_word[31:8]};
            2'b10:   ld2_word = {DM_mem_dout[15:0], lo_word[31:16]};
            2'b11:   ld2_word = {DM_mem_dout[23:0], lo_word[31:24]};
            default: ld2_word = lo_word;
        endcase
    end

    // Drive data_mem and pipeline outputs; everything quiet during reset
    always_comb begin
        MEM_mem_cmd    = `MEM_NONE;
        MEM_mem_addr   = 32'h0;
        MEM_mem_din    = 32'h0;
        MEM_load_data  = 32'h0;
        MEM_load_valid = 1'b0;
        MEM_stall      = 1'b0;
        MEM_misaligned = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    MEM_mem_addr = EX_mem_addr;
                    if (reject) begin
                        MEM_misaligned = 1'b1;
                    end else if (is_store && aligned) begin
                        MEM_mem_cmd = store_cmd(EX_mem_size);
                        MEM_mem_din = EX_mem_wdata;
                    end else if (is_store) begin
                        MEM_mem_cmd = `MEM_SB;
                        MEM_mem_din = {24'b0, EX_mem_wdata[7:0]};
                        MEM_stall   = 1'b1;
                    end else if (is_load && !crosses) begin
                        MEM_load_valid = 1'b1;
                        MEM_load_data  = extend(idle_word, EX_mem_size,
                                                EX_mem_unsigned);
                    end else if (is_load) begin
                        MEM_stall = 1'b1;
                    end
                end
                LD2: begin
                    MEM_mem_addr   = base_addr + 32'd4;
                    MEM_load_valid = 1'b1;
                    MEM_load_data  = extend(ld2_word, size_q, unsigned_q);
                end
                ST_SEQ: begin
                    MEM_mem_cmd  = `MEM_SB;
                    MEM_mem_addr = base_addr + {30'b0, byte_idx};
                    MEM_mem_din  = {24'b0, pick_byte(wdata_q, byte_idx)};
                    MEM_stall    = !seq_last;
                end
                default: begin
                    MEM_mem_cmd = `MEM_NONE;
                end
            endcase
        end
    end

    // Sequencer state and request latches, captured when leaving IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base_addr  <= 32'h0;
            lo_word    <= 32'h0;
            wdata_q    <= 32'h0;
            byte_idx   <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (SPLIT_MISALIGNED && is_store && !aligned) begin
                        state      <= ST_SEQ;
                        base_addr  <= EX_mem_addr;
                        wdata_q    <= EX_mem_wdata;
                        size_q     <= EX_mem_size;
                        unsigned_q <= EX_mem_unsigned;
                        byte_idx   <= 2'b01;
                    end else if (SPLIT_MISALIGNED && is_load && crosses) begin
                        state      <= LD2;
                        base_addr  <= EX_mem_addr;
                        lo_word    <= DM_mem_dout;
                        wdata_q    <= EX_mem_wdata;
                        size_q     <= EX_mem_size;
                        unsigned_q <= EX_mem_unsigned;
                    end
                end
                LD2: begin
                    state <= IDLE;
                end
                ST_SEQ: begin
                    if (seq_last) begin
                        state    <= IDLE;
                        byte_idx <= 2'b00;
                    end else begin
                        byte_idx <= byte_idx + 2'b01;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array data_mem model.
// A second instance covers the non-splitting configuration.

`ifndef MEM_NONE
`define MEM_NONE 4'h0
`endif
`ifndef MEM_SB
`define MEM_SB 4'h1
`endif
`ifndef MEM_SH
`define MEM_SH 4'h2
`endif
`ifndef MEM_SW
`define MEM_SW 4'h3
`endif

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op = 2'b00;
    logic [1:0]  n_op = 2'b00;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic [3:0]  cmd, n_cmd;
    logic [31:0] maddr, n_maddr;
    logic [31:0] din, n_din;
    logic [31:0] dout, n_dout;
    logic [31:0] ldata, n_ldata;
    logic        lvalid, n_lvalid;
    logic        stall, n_stall;
    logic        mis, n_mis;

    logic [7:0]  mem [0:1023];

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .EX_mem_op(op), .EX_mem_size(size),
        .EX_mem_unsigned(uns), .EX_mem_addr(addr),
        .EX_mem_wdata(wdata),
        .MEM_mem_cmd(cmd), .MEM_mem_addr(maddr),
        .MEM_mem_din(din), .DM_mem_dout(dout),
        .MEM_load_data(ldata), .MEM_load_valid(lvalid),
        .MEM_stall(stall), .MEM_misaligned(mis)
    );

    mem_access_unit #(.SPLIT_MISALIGNED(1'b0)) u_nosplit (
        .clk(clk), .rst(rst),
        .EX_mem_op(n_op), .EX_mem_size(size),
        .EX_mem_unsigned(uns), .EX_mem_addr(addr),
        .EX_mem_wdata(wdata),
        .MEM_mem_cmd(n_cmd), .MEM_mem_addr(n_maddr),
        .MEM_mem_din(n_din), .DM_mem_dout(n_dout),
        .MEM_load_data(n_ldata), .MEM_load_valid(n_lvalid),
        .MEM_stall(n_stall), .MEM_misaligned(n_mis)
    );

    // data_mem model: combinational word read, byte-lane writes
    wire [7:0] wi = maddr[9:2];
    wire [7:0] nwi = n_maddr[9:2];
    assign dout = {mem[{wi, 2'b11}], mem[{wi, 2'b10}],
                   mem[{wi, 2'b01}], mem[{wi, 2'b00}]};
    assign n_dout = {mem[{nwi, 2'b11}], mem[{nwi, 2'b10}],
                     mem[{nwi, 2'b01}], mem[{nwi, 2'b00}]};

    always @(posedge clk) begin
        case (cmd)
            `MEM_SB: mem[maddr[9:0]] <= din[7:0];
            `MEM_SH: begin
                mem[{maddr[9:1], 1'b0}] <= din[7:0];
                mem[{maddr[9:1], 1'b1}] <= din[15:8];
            end
            `MEM_SW: begin
                mem[{maddr[9:2], 2'b00}] <= din[7:0];
                mem[{maddr[9:2], 2'b01}] <= din[15:8];
                mem[{maddr[9:2], 2'b10}] <= din[23:16];
                mem[{maddr[9:2], 2'b11}] <= din[31:24];
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] word_at(input logic [9:0] a);
        return {mem[{a[9:2], 2'b11}], mem[{a[9:2], 2'b10}],
                mem[{a[9:2], 2'b01}], mem[{a[9:2], 2'b00}]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic [1:0] o, input logic [1:0] s,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] w);
        @(negedge clk);
        op = o; size = s; uns = u; addr = a; wdata = w;
        #1;
    endtask

    task automatic hold();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        // Reset: outputs quiet even with a store presented
        drive(2'b10, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        check("rst_cmd", {28'b0, cmd}, {28'b0, `MEM_NONE});
        check("rst_addr", maddr, 32'h0);
        check("rst_flags", {29'b0, stall, lvalid, mis}, 32'h0);
        rst = 1'b0;
        #1;
        check("sw_cmd", {28'b0, cmd}, {28'b0, `MEM_SW});
        check("sw_din", din, 32'hDEADBEEF);
        check("sw_stall", {31'b0, stall}, 32'h0);

        drive(2'b01, 2'b10, 1'b0, 32'h100, 32'h0);
        check("lw_valid", {31'b0, lvalid}, 32'h1);
        check("lw_data", ldata, 32'hDEADBEEF);
        drive(2'b01, 2'b00, 1'b0, 32'h103, 32'h0);
        check("lb_103", ldata, 32'hFFFFFFDE);
        drive(2'b01, 2'b00, 1'b1, 32'h103, 32'h0);
        check("lbu_103", ldata, 32'h000000DE);
        drive(2'b01, 2'b01, 1'b0, 32'h102, 32'h0);
        check("lh_102", ldata, 32'hFFFFDEAD);
        drive(2'b01, 2'b01, 1'b0, 32'h101, 32'h0);
        check("lh_101", ldata, 32'hFFFFADBE);
        check("lh_101_stall", {31'b0, stall}, 32'h0);

        // Misaligned word store split into bytes
        drive(2'b10, 2'b10, 1'b0, 32'h105, 32'h11223344);
        check("ss0_cmd", {28'b0, cmd}, {28'b0, `MEM_SB});
        check("ss0", {stall, 7'b0, din[7:0], maddr[15:0]}, 32'h80440105);
        hold();
        check("ss1", {stall, 7'b0, din[7:0], maddr[15:0]}, 32'h80330106);
        hold();
        check("ss2", {stall, 7'b0, din[7:0], maddr[15:0]}, 32'h80220107);
        hold();
        check("ss3", {stall, 7'b0, din[7:0], maddr[15:0]}, 32'h00110108);

        // Crossing loads
        drive(2'b01, 2'b10, 1'b0, 32'h105, 32'h0);
        check("mem_104", word_at(10'h104), 32'h22334400);
        check("mem_108", word_at(10'h108), 32'h00000011);
        check("lw105_c0", {31'b0, stall}, 32'h1);
        check("lw105_c0_v", {31'b0, lvalid}, 32'h0);
        check("lw105_c0_d", ldata, 32'h0);
        hold();
        check("lw105_c1_st", {31'b0, stall}, 32'h0);
        check("lw105_c1_a", maddr, 32'h109);
        check("lw105_data", ldata, 32'h11223344);
        drive(2'b01, 2'b01, 1'b0, 32'h107, 32'h0);
        check("lh107_c0", {30'b0, stall, lvalid}, 32'h2);
        hold();
        check("lh107_c1", {30'b0, stall, lvalid}, 32'h1);
        check("lh107_data", ldata, 32'h00001122);

        // Reset in the middle of a split store
        drive(2'b10, 2'b10, 1'b0, 32'h105, 32'h11223344);
        hold();
        check("abort_pre", {31'b0, stall}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_stall", {31'b0, stall}, 32'h0);
        check("abort_cmd", {28'b0, cmd}, {28'b0, `MEM_NONE});
        drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        drive(2'b10, 2'b10, 1'b0, 32'h200, 32'h5);
        check("sw200_cmd", {28'b0, cmd}, {28'b0, `MEM_SW});
        check("sw200_stall", {31'b0, stall}, 32'h0);

        // Halfword store wrapping the address space
        drive(2'b10, 2'b01, 1'b0, 32'hFFFFFFFF, 32'hA1B2);
        check("mem_200", word_at(10'h200), 32'h5);
        check("wrap_a0", maddr, 32'hFFFFFFFF);
        check("wrap_d0", {30'b0, stall, 1'b0} | {16'b0, din[7:0], 8'b0},
              32'h0000B202);
        hold();
        check("wrap_a1", maddr, 32'h0);
        check("wrap_d1", {23'b0, stall, din[7:0]}, 32'h000000A1);

        // Non-splitting instance
        drive(2'b00, 2'b10, 1'b0, 32'h102, 32'h12345678);
        n_op = 2'b10;
        #1;
        check("ns_sw_mis", {31'b0, n_mis}, 32'h1);
        check("ns_sw_cmd", {28'b0, n_cmd}, {28'b0, `MEM_NONE});
        check("ns_sw_stall", {31'b0, n_stall}, 32'h0);
        drive(2'b00, 2'b10, 1'b0, 32'h102, 32'h0);
        n_op = 2'b01;
        #1;
        check("ns_lw_mis", {31'b0, n_mis}, 32'h1);
        check("ns_lw_valid", {31'b0, n_lvalid}, 32'h0);
        check("ns_lw_data", n_ldata, 32'h0);
        drive(2'b00, 2'b01, 1'b0, 32'h101, 32'h0);
        check("ns_lh101_mis", {31'b0, n_mis}, 32'h1);
        drive(2'b00, 2'b10, 1'b0, 32'h100, 32'h0);
        check("ns_lw_ok", {n_mis, n_lvalid, 30'b0} ^ n_ldata,
              32'h40000000 ^ 32'hDEADBEEF);
        n_op = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
